// File: rtl/bus_copy_master.sv
// Bus initiator that copies a block of 32-bit words from a source address range to a
// destination range using alternating read/write transfers on the shared master bus.
module bus_copy_master #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_dout,
    input  logic              m_grant,
    input  logic [63:0]       m_din
);

    typedef enum logic [2:0] {IDLE, REQ, RD, RDW, WR, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  idx;
    logic [31:0]       buf_r;

    logic [LEN_W-1:0]  idx_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              unused_din_hi;

    assign idx_inc       = idx + LEN_W'(1);
    assign rd_addr       = src_r + ADDR_W'(idx);
    assign wr_addr       = dst_r + ADDR_W'(idx);
    assign unused_din_hi = ^m_din[63:32];

    // Only the low word of the read bus carries data; the index only advances on a granted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
            idx   <= '0;
            buf_r <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start && length != '0) begin
                        src_r <= src_addr;
                        dst_r <= dst_addr;
                        len_r <= length;
                        idx   <= '0;
                    end
                end
                RDW: begin
                    if (m_grant) buf_r <= m_din[31:0];
                end
                WR: begin
                    if (m_grant) idx <= idx_inc;
                end
                default: ;
            endcase
        end
    end

    // Losing grant mid-word sends the FSM back to REQ so the whole word is re-read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (length == '0) ? DONE : REQ;
            REQ:     if (m_grant) state_next = RD;
            RD:      state_next = m_grant ? RDW : REQ;
            RDW:     state_next = m_grant ? WR : REQ;
            WR: begin
                if (!m_grant)
                    state_next = REQ;
                else if (idx_inc == len_r)
                    state_next = DONE;
                else
                    state_next = RD;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = '0;
        m_dout    = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            REQ: m_req = 1'b1;
            RD, RDW: begin
                m_req     = 1'b1;
                m_address = rd_addr;
            end
            WR: begin
                m_req     = 1'b1;
                m_wr      = 1'b1;
                m_address = wr_addr;
                m_dout    = buf_r;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master: a vector table of copies with grant schedules,
// plus hand-written reset sequences.
module tb_bus_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_address;
    logic [31:0] m_dout;
    logic        m_grant;
    logic [63:0] m_din;

    bus_copy_master #(.ADDR_W(16), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .busy(busy), .done(done), .m_req(m_req), .m_wr(m_wr),
        .m_address(m_address), .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din)
    );

    always #5 clk = ~clk;

    // Slave model: every word reads back as 0xA0 plus its own address.
    assign m_din = {32'hDEADBEEF, 32'h000000A0 + {16'h0000, m_address}};

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    int          reqCycles = 0;
    int          doutBad   = 0;

    always @(negedge clk) begin
        if (m_req) reqCycles++;
        if (m_req && m_wr && m_grant) begin
            wrAddrQ.push_back(m_address);
            wrDataQ.push_back(m_dout);
        end
        if (!m_wr && m_dout != 32'h0) doutBad++;
    end

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  len;
        int          grantOn;
        int          dropFrom;
        int          dropTo;
        int          midStart;
        int          expDone;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic sched(input vec_t v, input int k);
        return (k >= v.grantOn) && !(k >= v.dropFrom && k <= v.dropTo);
    endfunction

    // Cycle k is the cycle after edge k; start is driven in cycle 0 and sampled at edge 1.
    task automatic applyStimulus(input vec_t v);
        int          k;
        bit          seen;
        logic [15:0] expAddr;
        logic [15:0] rdAddr;
        wrAddrQ.delete();
        wrDataQ.delete();
        reqCycles = 0;
        @(posedge clk); #1;
        m_grant  = sched(v, 0);
        start    = 1'b1;
        src_addr = v.src;
        dst_addr = v.dst;
        length   = v.len;
        @(posedge clk); #1;
        start   = 1'b0;
        m_grant = sched(v, 1);
        k    = 1;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (k == 1) checkOutput("busy_after_start", {31'h0, busy}, 32'h1);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); k++; #1;
                m_grant = sched(v, k);
                start   = (k == v.midStart);
                if (k == v.midStart) begin
                    src_addr = 16'h0300;
                    dst_addr = 16'h0400;
                    length   = 8'd5;
                end
            end
        end
        checkOutput("done_cycle", k, v.expDone);
        @(posedge clk); #1;
        m_grant = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_done", {29'h0, busy, done, m_req}, 32'h0);
        checkOutput("write_count", wrAddrQ.size(), {24'h0, v.len});
        for (int i = 0; i < int'(v.len) && i < wrAddrQ.size(); i++) begin
            expAddr = v.dst + 16'(i);
            rdAddr  = v.src + 16'(i);
            checkOutput("write_addr", {16'h0, wrAddrQ[i]}, {16'h0, expAddr});
            checkOutput("write_data", wrDataQ[i], 32'h000000A0 + {16'h0, rdAddr});
        end
        if (v.len == 8'd0) checkOutput("no_req_len0", reqCycles, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int doneHits;
        vecs[0] = '{src:16'h0010, dst:16'h0020, len:8'd3, grantOn:0, dropFrom:100, dropTo:0,  midStart:-1, expDone:11};
        vecs[1] = '{src:16'h0010, dst:16'h0020, len:8'd3, grantOn:5, dropFrom:100, dropTo:0,  midStart:-1, expDone:15};
        vecs[2] = '{src:16'h0010, dst:16'h0020, len:8'd3, grantOn:0, dropFrom:6,   dropTo:7,  midStart:-1, expDone:15};
        vecs[3] = '{src:16'h0050, dst:16'h0060, len:8'd0, grantOn:0, dropFrom:100, dropTo:0,  midStart:-1, expDone:1};
        vecs[4] = '{src:16'hFFFF, dst:16'h0040, len:8'd2, grantOn:0, dropFrom:100, dropTo:0,  midStart:-1, expDone:8};
        vecs[5] = '{src:16'h0100, dst:16'hFFFF, len:8'd2, grantOn:0, dropFrom:100, dropTo:0,  midStart:-1, expDone:8};

        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 16'h0;
        dst_addr = 16'h0;
        length   = 8'h0;
        m_grant  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        reqCycles = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_ctrl", {28'h0, m_req, m_wr, busy, done}, 32'h0);
            checkOutput("reset_addr", {16'h0, m_address}, 32'h0);
            checkOutput("reset_dout", m_dout, 32'h0);
        end
        checkOutput("idle_no_req", reqCycles, 32'h0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // A second start arriving mid-copy must leave the latched block untouched.
        applyStimulus('{src:16'h0010, dst:16'h0020, len:8'd3, grantOn:0, dropFrom:100, dropTo:0, midStart:4, expDone:11});

        // Reset during the first write abandons the copy without a done pulse.
        @(posedge clk); #1;
        start    = 1'b1;
        src_addr = 16'h0010;
        dst_addr = 16'h0020;
        length   = 8'd3;
        m_grant  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in_wr_before_reset", {31'h0, m_wr}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ctrl", {28'h0, m_req, m_wr, busy, done}, 32'h0);
        checkOutput("post_reset_addr", {16'h0, m_address}, 32'h0);
        checkOutput("post_reset_dout", m_dout, 32'h0);
        doneHits = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) doneHits++;
        end
        checkOutput("no_done_after_reset", doneHits, 32'h0);
        checkOutput("dout_zero_outside_wr", doutBad, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
